dcache_mem_ctrl: RTL and testbench

- Sits directly downstream of the data cache, between its miss/eviction outputs and the word-wide main-memory port.
- On a cache miss it optionally writes back the evicted dirty line, then fetches the requested 128-bit line as four 32-bit beats.
- It returns the assembled line to the cache with a level ready signal, using a 4-phase request/ready handshake.

---
 rtl/dcache_mem_ctrl_pkg.sv | 26 ++
 rtl/dcache_mem_ctrl_if.sv | 35 +++
 rtl/dcache_mem_ctrl.sv | 105 ++++++++++
 tb/tb_dcache_mem_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared sizing constants, FSM state type and address helper for the
// data-cache memory controller.
package dcache_mem_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 20;
    localparam int LINE_WIDTH     = 128;
    localparam int WORD_WIDTH     = 32;
    localparam int BEATS          = LINE_WIDTH / WORD_WIDTH;

    typedef enum logic [1:0] {
        DMC_IDLE = 2'd0,
        DMC_WB   = 2'd1,
        DMC_FILL = 2'd2,
        DMC_RESP = 2'd3
    } dmc_state_t;

    // Beat address inside a 16-byte line; the base has its low nibble clear,
    // so OR-ing the beat offset can never carry out of the line.
    function automatic logic [MEM_ADDR_WIDTH-1:0] beat_addr(
        input logic [MEM_ADDR_WIDTH-1:0] base,
        input logic [1:0]                beat
    );
        return base | MEM_ADDR_WIDTH'({beat, 2'b00});
    endfunction

endpackage

// File: rtl/dcache_mem_ctrl_if.sv
// Cache-side miss/writeback signals and word-wide memory port of the
// data-cache memory controller. slave = controller, master = environment.
interface dcache_mem_ctrl_if;
    import dcache_mem_ctrl_pkg::*;

    logic                      req_valid;
    logic [MEM_ADDR_WIDTH-1:0] req_addr;
    logic                      wb_valid;
    logic [MEM_ADDR_WIDTH-1:0] wb_addr;
    logic [LINE_WIDTH-1:0]     wb_data;
    logic [LINE_WIDTH-1:0]     fill_data;
    logic                      fill_rdy;
    logic                      busy;
    logic                      mem_req;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0]     mem_wdata;
    logic [WORD_WIDTH-1:0]     mem_rdata;
    logic                      mem_ack;

    modport slave (
        input  req_valid, req_addr, wb_valid, wb_addr, wb_data,
        input  mem_rdata, mem_ack,
        output fill_data, fill_rdy, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_addr, wb_valid, wb_addr, wb_data,
        output mem_rdata, mem_ack,
        input  fill_data, fill_rdy, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_mem_ctrl.sv
// Data-cache miss handler: optional 4-beat writeback of the dirty victim,
// 4-beat line fill, then a level fill_rdy held until the request drops.
module dcache_mem_ctrl
    import dcache_mem_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    dcache_mem_ctrl_if.slave bus
);

    dmc_state_t                r_state;
    dmc_state_t                w_next_state;
    logic [1:0]                r_beat;
    logic                      r_gap;
    logic [MEM_ADDR_WIDTH-1:0] r_req_base;
    logic [MEM_ADDR_WIDTH-1:0] r_wb_base;
    logic [LINE_WIDTH-1:0]     r_wb_data;
    logic [LINE_WIDTH-1:0]     r_fill_data;
    logic                      w_mem_req;
    logic                      w_ack;
    logic                      w_last;

    // The first FILL cycle after a writeback is held idle (r_gap) so mem_req
    // drops for exactly one cycle while mem_we flips.
    assign w_mem_req = (r_state == DMC_WB) || ((r_state == DMC_FILL) && !r_gap);
    assign w_ack     = bus.mem_ack && w_mem_req;
    assign w_last    = w_ack && (r_beat == 2'(BEATS - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= DMC_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DMC_IDLE: if (bus.req_valid) w_next_state = bus.wb_valid ? DMC_WB : DMC_FILL;
            DMC_WB:   if (w_last)        w_next_state = DMC_FILL;
            DMC_FILL: if (w_last)        w_next_state = DMC_RESP;
            DMC_RESP: if (!bus.req_valid) w_next_state = DMC_IDLE;
            default:                     w_next_state = DMC_IDLE;
        endcase
    end

    // Request latching, beat counter and fill-line assembly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat      <= '0;
            r_gap       <= 1'b0;
            r_req_base  <= '0;
            r_wb_base   <= '0;
            r_wb_data   <= '0;
            r_fill_data <= '0;
        end else begin
            case (r_state)
                DMC_IDLE: begin
                    r_beat <= '0;
                    r_gap  <= 1'b0;
                    if (bus.req_valid) begin
                        r_req_base <= bus.req_addr & ~MEM_ADDR_WIDTH'(15);
                        if (bus.wb_valid) begin
                            r_wb_base <= bus.wb_addr & ~MEM_ADDR_WIDTH'(15);
                            r_wb_data <= bus.wb_data;
                        end
                    end
                end
                DMC_WB: begin
                    if (w_ack) r_beat <= r_beat + 2'd1;
                    if (w_last) r_gap <= 1'b1;
                end
                DMC_FILL: begin
                    r_gap <= 1'b0;
                    if (w_ack) begin
                        r_fill_data[int'(r_beat) * WORD_WIDTH +: WORD_WIDTH] <= bus.mem_rdata;
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from state and latched request
    always_comb begin
        bus.mem_req   = w_mem_req;
        bus.mem_we    = (r_state == DMC_WB);
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (r_state == DMC_WB) begin
            bus.mem_addr  = beat_addr(r_wb_base, r_beat);
            bus.mem_wdata = r_wb_data[int'(r_beat) * WORD_WIDTH +: WORD_WIDTH];
        end else if (r_state == DMC_FILL) begin
            bus.mem_addr  = beat_addr(r_req_base, r_beat);
        end
        bus.fill_data = r_fill_data;
        bus.fill_rdy  = (r_state == DMC_RESP);
        bus.busy      = (r_state != DMC_IDLE);
    end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl: expected memory beats and fill lines
// are queued when a request is issued and checked as the DUT produces them.
module tb_dcache_mem_ctrl;
    import dcache_mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dcache_mem_ctrl_if bus();

    dcache_mem_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t          q[$];
    logic [127:0]   fill_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_fill_data"}, bus.fill_data, '0);
        chk({tag, "_fill_rdy"},  bus.fill_rdy,  0);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_mem_req"},   bus.mem_req,   0);
        chk({tag, "_mem_we"},    bus.mem_we,    0);
        chk({tag, "_mem_addr"},  bus.mem_addr,  0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic push_txn(input logic [19:0] raddr, input logic wbv, input logic [19:0] waddr,
                            input logic [127:0] wdata, input logic [127:0] rline);
        beat_t b;
        logic [19:0] rbase, wbase;
        rbase = raddr & 20'hFFFF0;
        wbase = waddr & 20'hFFFF0;
        if (wbv) begin
            for (int i = 0; i < 4; i++) begin
                b.we = 1'b1; b.addr = wbase + 20'(4 * i); b.data = wdata[32 * i +: 32];
                q.push_back(b);
            end
        end
        for (int i = 0; i < 4; i++) begin
            b.we = 1'b0; b.addr = rbase + 20'(4 * i); b.data = '0;
            q.push_back(b);
        end
        fill_q.push_back(rline);
    endtask

    // Called at a negedge; returns at a negedge (or just after a posedge on abort).
    task automatic run_txn(input logic [19:0] raddr, input logic wbv, input logic [19:0] waddr,
                           input logic [127:0] wdata, input logic [127:0] rline,
                           input int stall, input int exp_lat, input int hold, input int abort_reads);
        beat_t        e;
        logic [127:0] exp_fill;
        int           cyc, cnt, rd_i, gaps;
        bit           done;
        push_txn(raddr, wbv, waddr, wdata, rline);
        bus.req_valid = 1'b1;
        bus.req_addr  = raddr;
        bus.wb_valid  = wbv;
        bus.wb_addr   = waddr;
        bus.wb_data   = wdata;
        cyc = 1; cnt = 0; rd_i = 0; gaps = 0; done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk);
            cyc++;
            if (abort_reads > 0 && rd_i >= abort_reads) begin
                #1;
                bus.mem_ack = 1'b0;
                return;
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            // request-side inputs outside IDLE must be ignored
            bus.req_addr = 20'hFFFFF;
            bus.wb_valid = ~wbv;
            bus.wb_addr  = 20'hFFFF0;
            bus.wb_data  = '1;
            if (bus.fill_rdy) begin
                done = 1;
            end else if (bus.mem_req) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", bus.mem_req, 0);
                    done = 1;
                end else begin
                    e = q[0];
                    chk("beat_we",   bus.mem_we,   e.we);
                    chk("beat_addr", bus.mem_addr, e.addr);
                    if (e.we) chk("beat_wdata", bus.mem_wdata, e.data);
                    if (cnt == stall) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = e.we ? 32'hDEADBEEF : rline[32 * rd_i +: 32];
                        if (!e.we) rd_i++;
                        void'(q.pop_front());
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                if (bus.busy) gaps++;
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hBAD0BAD0;
            end
        end
        chk("fill_rdy_seen", done, 1);
        if (done) begin
            exp_fill = fill_q.pop_front();
            chk("latency",      cyc,           exp_lat);
            chk("gap_cycles",   gaps,          wbv ? 1 : 0);
            chk("beats_left",   q.size(),      0);
            chk("fill_data",    bus.fill_data, exp_fill);
            chk("resp_mem_req", bus.mem_req,   0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_fill_rdy", bus.fill_rdy, 1);
                chk("hold_mem_req",  bus.mem_req,  0);
                chk("hold_busy",     bus.busy,     1);
            end
            bus.req_valid = 1'b0;
            @(negedge clk);
            chk("drop_busy",      bus.busy,      0);
            chk("drop_fill_rdy",  bus.fill_rdy,  0);
            chk("drop_fill_data", bus.fill_data, exp_fill);
        end else begin
            bus.req_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        #3;
        check_zero("init");
        @(negedge clk);
        reset = 1'b1;

        // clean miss, same-cycle acks
        run_txn(20'h00120, 1'b0, 20'h0, '0,
                128'h44444444_33333333_22222222_11111111, 0, 6, 2, 0);
        // dirty miss
        run_txn(20'h00120, 1'b1, 20'h00010, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD,
                128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C, 0, 11, 0, 0);
        // 3-cycle ack stalls on every beat
        run_txn(20'h00450, 1'b0, 20'h0, '0,
                128'h89ABCDEF_01234567_FEDCBA98_76543210, 3, 18, 0, 0);
        run_txn(20'h00870, 1'b1, 20'h00A38, 128'h13579BDF_2468ACE0_0BADF00D_CAFEBABE,
                128'h55555555_66666666_77777777_88888888, 3, 35, 1, 0);
        // unaligned request, req_valid held 5 cycles past fill_rdy
        run_txn(20'h0012C, 1'b0, 20'h0, '0,
                128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4, 0, 6, 5, 0);
        // reset asserted between clock edges after the beat-1 fill ack
        run_txn(20'h00300, 1'b0, 20'h0, '0,
                128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 0, 6, 0, 2);
        #2;
        reset = 1'b0;
        #1;
        check_zero("midreset");
        bus.req_valid = 1'b0;
        q.delete();
        fill_q.delete();
        @(negedge clk);
        reset = 1'b1;
        // next request restarts at beat 0
        run_txn(20'h00340, 1'b1, 20'h00FF4, 128'h11223344_55667788_99AABBCC_DDEEFF00,
                128'hFEEDFACE_C0FFEE00_12121212_34343434, 0, 11, 0, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
